// File: rtl/uart_lcd_writer.sv
// Buffers received UART bytes and renders them on a 16x2 HD44780 LCD over
// the 8-bit parallel bus: power-up init, E-strobe timing, cursor and control codes.
module uart_lcd_writer #(
  parameter int FIFO_DEPTH   = 16,
  parameter int PWR_WAIT     = 2_500_000,
  parameter int SETUP_CYCLES = 3,
  parameter int E_CYCLES     = 12,
  parameter int CMD_WAIT     = 2_500,
  parameter int CLR_WAIT     = 100_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_e,
  output logic       o_busy,
  output logic       o_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {PWR, IDLE, SETUP, PULSE, WAIT} state_t;

  state_t          r_state;
  logic [31:0]     r_cnt;
  logic [7:0]      r_data;
  logic            r_rs, r_e, r_busy, r_ovf;
  logic            r_row;
  logic [4:0]      r_col;
  logic            r_init;
  logic [1:0]      r_init_idx;
  logic            r_pend;
  logic [7:0]      r_pend_data;
  logic            r_clr;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wp, r_rp;
  logic [AW:0]     r_fcnt;

  logic            w_empty, w_full, w_pop, w_push;
  logic [AW:0]     w_fcnt_nxt;
  logic [7:0]      w_byte;
  logic [31:0]     w_wait_last;
  logic [1:0]      w_idx_nxt;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  assign w_empty   = (r_fcnt == '0);
  assign w_full    = (r_fcnt == (AW+1)'(FIFO_DEPTH));
  assign w_pop     = (r_state == IDLE) && !w_empty;
  // A full FIFO still accepts a write when the same cycle pops.
  assign w_push    = i_valid && (!w_full || w_pop);
  assign w_byte    = r_mem[r_rp];
  assign w_idx_nxt = r_init_idx + 2'd1;
  assign w_wait_last = r_clr ? 32'(CLR_WAIT - 1) : 32'(CMD_WAIT - 1);

  always_comb begin
    w_fcnt_nxt = r_fcnt;
    if (w_push && !w_pop)      w_fcnt_nxt = r_fcnt + 1'b1;
    else if (!w_push && w_pop) w_fcnt_nxt = r_fcnt - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_fcnt <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_fcnt <= w_fcnt_nxt;
      if (i_valid && !w_push) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= PWR;
      r_cnt       <= '0;
      r_data      <= 8'h00;
      r_rs        <= 1'b0;
      r_e         <= 1'b0;
      r_busy      <= 1'b1;
      r_row       <= 1'b0;
      r_col       <= 5'd0;
      r_init      <= 1'b1;
      r_init_idx  <= 2'd0;
      r_pend      <= 1'b0;
      r_pend_data <= 8'h00;
      r_clr       <= 1'b0;
    end else begin
      case (r_state)
        PWR: begin
          if (r_cnt == 32'(PWR_WAIT - 1)) begin
            r_cnt      <= '0;
            r_state    <= SETUP;
            r_data     <= init_cmd(2'd0);
            r_rs       <= 1'b0;
            r_clr      <= 1'b0;
            r_init_idx <= 2'd0;
          end else r_cnt <= r_cnt + 1'b1;
        end
        SETUP: begin
          if (r_cnt == 32'(SETUP_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_e     <= 1'b1;
            r_state <= PULSE;
          end else r_cnt <= r_cnt + 1'b1;
        end
        PULSE: begin
          if (r_cnt == 32'(E_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_e     <= 1'b0;
            r_state <= WAIT;
          end else r_cnt <= r_cnt + 1'b1;
        end
        WAIT: begin
          if (r_cnt == w_wait_last) begin
            r_cnt <= '0;
            if (r_init) begin
              if (r_init_idx == 2'd3) begin
                r_init  <= 1'b0;
                r_clr   <= 1'b0;
                r_state <= IDLE;
                r_busy  <= (w_fcnt_nxt != '0);
              end else begin
                r_init_idx <= w_idx_nxt;
                r_data     <= init_cmd(w_idx_nxt);
                r_clr      <= (w_idx_nxt == 2'd2);
                r_state    <= SETUP;
              end
            end else if (r_pend) begin
              // second half of a wrapped character: no IDLE cycle in between
              r_pend  <= 1'b0;
              r_rs    <= 1'b1;
              r_data  <= r_pend_data;
              r_clr   <= 1'b0;
              r_state <= SETUP;
            end else begin
              r_state <= IDLE;
              r_busy  <= (w_fcnt_nxt != '0);
            end
          end else r_cnt <= r_cnt + 1'b1;
        end
        IDLE: begin
          r_busy <= (w_fcnt_nxt != '0);
          if (w_pop) begin
            if (w_byte >= 8'h20 && w_byte <= 8'h7E) begin
              r_busy  <= 1'b1;
              r_clr   <= 1'b0;
              r_state <= SETUP;
              if (r_col == 5'd16) begin
                r_data      <= r_row ? 8'h80 : 8'hC0;
                r_rs        <= 1'b0;
                r_pend      <= 1'b1;
                r_pend_data <= w_byte;
                r_row       <= ~r_row;
                r_col       <= 5'd1;
              end else begin
                r_data <= w_byte;
                r_rs   <= 1'b1;
                r_col  <= r_col + 5'd1;
              end
            end else if (w_byte == 8'h0A) begin
              r_busy  <= 1'b1;
              r_data  <= r_row ? 8'h80 : 8'hC0;
              r_rs    <= 1'b0;
              r_clr   <= 1'b0;
              r_row   <= ~r_row;
              r_col   <= 5'd0;
              r_state <= SETUP;
            end else if (w_byte == 8'h0C) begin
              r_busy  <= 1'b1;
              r_data  <= 8'h01;
              r_rs    <= 1'b0;
              r_clr   <= 1'b1;
              r_row   <= 1'b0;
              r_col   <= 5'd0;
              r_state <= SETUP;
            end
          end
        end
        default: r_state <= PWR;
      endcase
    end
  end

  assign o_lcd_data = r_data;
  assign o_lcd_rs   = r_rs;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_e    = r_e;
  assign o_busy     = r_busy;
  assign o_overflow = r_ovf;
endmodule

// File: doc/uart_lcd_writer.md
# uart_lcd_writer

Consumer stage for the UART receiver: it takes each received byte (data plus one-cycle ready strobe), buffers it in a small FIFO, and renders it on the DE0-Nano's 16x2 HD44780 character LCD over its 8-bit parallel bus. The block runs the LCD power-up initialisation, generates all E-strobe and command-wait timing, tracks the cursor, and interprets three control codes (line feed, form feed, wrap).

## Interface
- FIFO_DEPTH, 16: byte FIFO entries (power of two, >=2).
- PWR_WAIT, 2_500_000: cycles after reset before the first init command (50 ms at 50 MHz).
- SETUP_CYCLES, 3: cycles RS/DATA are stable with E low before E rises.
- E_CYCLES, 12: E high width in cycles.
- CMD_WAIT, 2_500: cycles after E falls for normal commands and data writes.
- CLR_WAIT, 100_000: cycles after E falls for clear (0x01).
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_data  in  8  received byte; sampled only when i_valid=1.
- i_valid  in  1  one-cycle strobe, driven by the receiver's ready output.
- o_lcd_data  out  8  LCD DB7..DB0.
- o_lcd_rs  out  1  0 = command, 1 = character data.
- o_lcd_rw  out  1  constant 0 (write only).
- o_lcd_e  out  1  LCD enable strobe.
- o_busy  out  1  1 while initialising or while the FIFO is non-empty or a transaction is in flight.
- o_overflow  out  1  sticky; set when a byte is dropped because the FIFO is full.

## Operation
- Reset values: o_lcd_data=0x00, o_lcd_rs=0, o_lcd_rw=0, o_lcd_e=0, o_busy=1, o_overflow=0. FIFO empty, cursor row=0 col=0, FSM in PWR.
- Reset mid-transaction: outputs take reset values on the next edge; FIFO contents are discarded; the full init sequence restarts.
- FIFO: writes on i_valid when not full. When full, the byte is dropped and o_overflow is set. A write and a pop in the same cycle are both performed, even when full.
- FSM states: PWR (count PWR_WAIT) -> INIT (issue 0x38, 0x0C, 0x01, 0x06 in order, using CLR_WAIT after 0x01) -> IDLE -> SETUP -> PULSE -> WAIT -> back to IDLE, or to the next queued sub-operation.
- IDLE pops one byte when the FIFO is non-empty and decodes it:
  - 0x20..0x7E printable: if col==16, first issue the address command for (row^1, 0) and set row^=1, col=0. Then write the char with RS=1 and increment col.
  - 0x0A LF: row^=1, col=0, issue address command 0x80|(row?0x40:0x00).
  - 0x0C FF: issue 0x01 with CLR_WAIT; row=0, col=0.
  - Any other byte: discarded with no bus activity. Return to IDLE next cycle.
- Address command: 0x80 for row 0, 0xC0 for row 1. Row wraps 1->0 without clearing the display.
- Each bus transaction drives RS and DATA on entry to SETUP and holds them through WAIT. E is high only in PULSE.
- col is 5 bits, range 0..16. row is 1 bit.

## Timing
- i_valid at edge N: byte readable from FIFO at N+1. If IDLE at N+1, pop at N+1 and enter SETUP at N+2.
- One transaction = SETUP_CYCLES + E_CYCLES + wait cycles, where wait is CMD_WAIT or CLR_WAIT. E rises exactly SETUP_CYCLES cycles after SETUP entry.
- Wrapped printable = two back-to-back transactions (address, then data), with no IDLE cycle between them.
- o_busy falls the cycle after WAIT ends with the FIFO empty. It never drops between init commands.
- o_lcd_e never glitches and is never high while RS/DATA change.

## Test plan
Bench parameters: PWR_WAIT=20, SETUP_CYCLES=2, E_CYCLES=3, CMD_WAIT=5, CLR_WAIT=9, FIFO_DEPTH=4.
- Init: release reset -> after 20 cycles, E pulses carry 0x38, 0x0C, 0x01, 0x06 with RS=0. The gap after 0x01 is 9 cycles; o_busy falls after the last WAIT.
- Single char: push 0x41 after init -> one transaction with RS=1, DATA=0x41, E high for 3 cycles starting 2 cycles after SETUP entry, 10 cycles total. Then o_busy=0.
- Wrap: push 17 x 0x58 (pacing pushes to avoid overflow) -> 16 data writes, then command 0xC0, then data 0x58 on row 1.
- Controls: push 0x0A, 0x0C, 0x07 -> command 0xC0; command 0x01 with a 9-cycle wait; no bus activity for 0x07. Cursor ends at row 0, col 0.
- Overflow: push 6 bytes on consecutive cycles during init -> 4 stored, o_overflow=1 and stays 1. After init, exactly 4 transactions occur.
- Reset mid-PULSE: assert i_rst while o_lcd_e=1 -> next cycle o_lcd_e=0, o_lcd_data=0x00, o_busy=1, FIFO empty. The init sequence restarts after 20 cycles.
